ascii_to_morse_tx: RTL and testbench

Transmit-side counterpart to the Morse-to-ASCII receiver. It accepts one 8-bit ASCII character per valid/ready handshake and converts it to Morse code. It then drives a single keying output with standard timing: dot = 1 unit, dash = 3 units, element gap = 1 unit, letter gap = 3 units, word gap = 7 units. It sits between a character source (UART RX, switches, or a ROM message player) and an LED, buzzer or key line.

---
 rtl/ascii_to_morse_tx.sv | 173 +++++++++++++++++
 tb/tb_ascii_to_morse_tx.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ascii_to_morse_tx.sv
// ASCII to Morse keyer: one character per valid/ready handshake, keyed out with standard unit timing.
// Optional build macro MORSE_PUNCT_EN adds . , ? / = to the character table.
module ascii_to_morse_tx #(
  parameter int unsigned UNIT_CYCLES = 5_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] ascii_in,
  input  logic       ascii_valid,
  output logic       ascii_ready,
  output logic       key_out,
  output logic       busy,
  output logic       invalid_char
);

  localparam int unsigned CntW = $clog2(UNIT_CYCLES + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(UNIT_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StMark, StElemGap, StLetterGap, StWordGap} state_e;

  state_e          r_state, w_state_nxt;
  logic [CntW-1:0] r_unit_cnt;
  logic [1:0]      r_units;
  logic [5:0]      r_pat;
  logic [2:0]      r_len;
  logic            r_key;
  logic            r_invalid;

  logic [7:0]      w_upper;
  logic [2:0]      w_lut_len;
  logic [5:0]      w_lut_pat;
  logic            w_accept;
  logic            w_is_space;
  logic            w_tick;
  logic [1:0]      w_need;
  logic            w_last_unit;
  logic            w_state_chg;

  assign w_accept    = ascii_valid && (r_state == StIdle);
  assign w_is_space  = (ascii_in == 8'h20);
  assign w_tick      = (r_unit_cnt == LastCnt);
  assign w_last_unit = w_tick && (r_units == w_need);
  assign w_state_chg = (w_state_nxt != r_state);

  always_comb begin
    w_upper = ascii_in;
    if (ascii_in >= 8'h61 && ascii_in <= 8'h7A) w_upper = ascii_in - 8'h20;
  end

  // Patterns are left-aligned: bit 5 is the first element, 1 = dash.
  always_comb begin
    {w_lut_len, w_lut_pat} = {3'd0, 6'b000000};
    case (w_upper)
      "A": {w_lut_len, w_lut_pat} = {3'd2, 6'b010000};
      "B": {w_lut_len, w_lut_pat} = {3'd4, 6'b100000};
      "C": {w_lut_len, w_lut_pat} = {3'd4, 6'b101000};
      "D": {w_lut_len, w_lut_pat} = {3'd3, 6'b100000};
      "E": {w_lut_len, w_lut_pat} = {3'd1, 6'b000000};
      "F": {w_lut_len, w_lut_pat} = {3'd4, 6'b001000};
      "G": {w_lut_len, w_lut_pat} = {3'd3, 6'b110000};
      "H": {w_lut_len, w_lut_pat} = {3'd4, 6'b000000};
      "I": {w_lut_len, w_lut_pat} = {3'd2, 6'b000000};
      "J": {w_lut_len, w_lut_pat} = {3'd4, 6'b011100};
      "K": {w_lut_len, w_lut_pat} = {3'd3, 6'b101000};
      "L": {w_lut_len, w_lut_pat} = {3'd4, 6'b010000};
      "M": {w_lut_len, w_lut_pat} = {3'd2, 6'b110000};
      "N": {w_lut_len, w_lut_pat} = {3'd2, 6'b100000};
      "O": {w_lut_len, w_lut_pat} = {3'd3, 6'b111000};
      "P": {w_lut_len, w_lut_pat} = {3'd4, 6'b011000};
      "Q": {w_lut_len, w_lut_pat} = {3'd4, 6'b110100};
      "R": {w_lut_len, w_lut_pat} = {3'd3, 6'b010000};
      "S": {w_lut_len, w_lut_pat} = {3'd3, 6'b000000};
      "T": {w_lut_len, w_lut_pat} = {3'd1, 6'b100000};
      "U": {w_lut_len, w_lut_pat} = {3'd3, 6'b001000};
      "V": {w_lut_len, w_lut_pat} = {3'd4, 6'b000100};
      "W": {w_lut_len, w_lut_pat} = {3'd3, 6'b011000};
      "X": {w_lut_len, w_lut_pat} = {3'd4, 6'b100100};
      "Y": {w_lut_len, w_lut_pat} = {3'd4, 6'b101100};
      "Z": {w_lut_len, w_lut_pat} = {3'd4, 6'b110000};
      "0": {w_lut_len, w_lut_pat} = {3'd5, 6'b111110};
      "1": {w_lut_len, w_lut_pat} = {3'd5, 6'b011110};
      "2": {w_lut_len, w_lut_pat} = {3'd5, 6'b001110};
      "3": {w_lut_len, w_lut_pat} = {3'd5, 6'b000110};
      "4": {w_lut_len, w_lut_pat} = {3'd5, 6'b000010};
      "5": {w_lut_len, w_lut_pat} = {3'd5, 6'b000000};
      "6": {w_lut_len, w_lut_pat} = {3'd5, 6'b100000};
      "7": {w_lut_len, w_lut_pat} = {3'd5, 6'b110000};
      "8": {w_lut_len, w_lut_pat} = {3'd5, 6'b111000};
      "9": {w_lut_len, w_lut_pat} = {3'd5, 6'b111100};
`ifdef MORSE_PUNCT_EN
      ".": {w_lut_len, w_lut_pat} = {3'd6, 6'b010101};
      ",": {w_lut_len, w_lut_pat} = {3'd6, 6'b110011};
      "?": {w_lut_len, w_lut_pat} = {3'd6, 6'b001100};
      "/": {w_lut_len, w_lut_pat} = {3'd5, 6'b100100};
      "=": {w_lut_len, w_lut_pat} = {3'd5, 6'b100010};
`else
`endif
      default: {w_lut_len, w_lut_pat} = {3'd0, 6'b000000};
    endcase
  end

  // Units still owed in the current state, minus one.
  always_comb begin
    w_need = 2'd0;
    case (r_state)
      StMark:      w_need = r_pat[5] ? 2'd2 : 2'd0;
      StElemGap:   w_need = 2'd0;
      StLetterGap: w_need = 2'd2;
      StWordGap:   w_need = 2'd3;
      default:     w_need = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= StIdle;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle: begin
        if (w_accept) begin
          if (w_lut_len != 3'd0) w_state_nxt = StMark;
          else if (w_is_space)   w_state_nxt = StWordGap;
        end
      end
      StMark:      if (w_last_unit) w_state_nxt = (r_len == 3'd1) ? StLetterGap : StElemGap;
      StElemGap:   if (w_last_unit) w_state_nxt = StMark;
      StLetterGap: if (w_last_unit) w_state_nxt = StIdle;
      StWordGap:   if (w_last_unit) w_state_nxt = StIdle;
      default:     w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    ascii_ready  = (r_state == StIdle);
    busy         = (r_state != StIdle);
    key_out      = r_key;
    invalid_char = r_invalid;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_unit_cnt <= '0;
      r_units    <= 2'd0;
      r_pat      <= 6'd0;
      r_len      <= 3'd0;
      r_key      <= 1'b0;
      r_invalid  <= 1'b0;
    end else begin
      r_key     <= (w_state_nxt == StMark);
      r_invalid <= w_accept && (w_lut_len == 3'd0) && !w_is_space;
      if (w_state_chg || r_state == StIdle) begin
        r_unit_cnt <= '0;
        r_units    <= 2'd0;
      end else if (w_tick) begin
        r_unit_cnt <= '0;
        r_units    <= r_units + 2'd1;
      end else begin
        r_unit_cnt <= r_unit_cnt + 1'b1;
      end
      if (w_accept) begin
        r_pat <= w_lut_pat;
        r_len <= w_lut_len;
      end else if (r_state == StElemGap && w_last_unit) begin
        r_pat <= {r_pat[4:0], 1'b0};
        r_len <= r_len - 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_ascii_to_morse_tx.sv
// Bench for ascii_to_morse_tx: two instances (U=3 and U=1) checked cycle by cycle against
// a dot/dash string model of each character.
module tb_ascii_to_morse_tx;

  localparam int unsigned UA = 3;
  localparam int unsigned UB = 1;

  logic       clk = 1'b0;
  logic       rst [2];
  logic [7:0] ain [2];
  logic       vld [2];
  logic       rdy [2];
  logic       key [2];
  logic       bsy [2];
  logic       inv [2];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int first_mark [2];
  int last_mark  [2];
  bit exp_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ascii_to_morse_tx #(.UNIT_CYCLES(UA)) dut_a (
    .clk(clk), .reset(rst[0]), .ascii_in(ain[0]), .ascii_valid(vld[0]),
    .ascii_ready(rdy[0]), .key_out(key[0]), .busy(bsy[0]), .invalid_char(inv[0])
  );

  ascii_to_morse_tx #(.UNIT_CYCLES(UB)) dut_b (
    .clk(clk), .reset(rst[1]), .ascii_in(ain[1]), .ascii_valid(vld[1]),
    .ascii_ready(rdy[1]), .key_out(key[1]), .busy(bsy[1]), .invalid_char(inv[1])
  );

  function automatic string morse_of(input logic [7:0] c);
    logic [7:0] u;
    u = (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
    case (u)
      "A": return ".-";    "B": return "-...";  "C": return "-.-.";  "D": return "-..";
      "E": return ".";     "F": return "..-.";  "G": return "--.";   "H": return "....";
      "I": return "..";    "J": return ".---";  "K": return "-.-";   "L": return ".-..";
      "M": return "--";    "N": return "-.";    "O": return "---";   "P": return ".--.";
      "Q": return "--.-";  "R": return ".-.";   "S": return "...";   "T": return "-";
      "U": return "..-";   "V": return "...-";  "W": return ".--";   "X": return "-..-";
      "Y": return "-.--";  "Z": return "--..";
      "0": return "-----"; "1": return ".----"; "2": return "..---"; "3": return "...--";
      "4": return "....-"; "5": return "....."; "6": return "-...."; "7": return "--...";
      "8": return "---.."; "9": return "----.";
`ifdef MORSE_PUNCT_EN
      ".": return ".-.-.-"; ",": return "--..--"; "?": return "..--..";
      "/": return "-..-.";  "=": return "-...-";
`endif
      default: return "";
    endcase
  endfunction

  // Expected key_out, one entry per cycle from T+1 until ascii_ready returns.
  function automatic void build_expect(input logic [7:0] c, input int u);
    string m;
    m = morse_of(c);
    exp_q.delete();
    if (c == 8'h20) begin
      repeat (4 * u) exp_q.push_back(1'b0);
    end else if (m.len() > 0) begin
      for (int i = 0; i < m.len(); i++) begin
        repeat (((m[i] == "-") ? 3 : 1) * u) exp_q.push_back(1'b1);
        if (i < m.len() - 1) repeat (u) exp_q.push_back(1'b0);
      end
      repeat (3 * u) exp_q.push_back(1'b0);
    end
  endfunction

  // Called at a negedge; returns at the negedge of the cycle ascii_ready is back
  // (or at T+1 for dropped characters, or after stop_after cycles if stop_after >= 0).
  task automatic send(input int d, input logic [7:0] c, input int stop_after);
    int u;
    int t;
    bit seen;
    u = (d == 0) ? UA : UB;
    build_expect(c, u);
    ain[d] = c;
    vld[d] = 1'b1;
    t = 0;
    while (rdy[d] !== 1'b1 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    n_chk++;
    if (rdy[d] !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_wait d%0d char=%h: ready=%b, required 1 within 1000 cycles", d, c, rdy[d]);
      vld[d] = 1'b0;
      return;
    end
    @(negedge clk);
    vld[d] = 1'b0;
    ain[d] = 8'($urandom);
    if (exp_q.size() == 0 && c != 8'h20) begin
      n_chk++;
      if (inv[d] !== 1'b1 || key[d] !== 1'b0 || rdy[d] !== 1'b1 || bsy[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL drop d%0d char=%h: inv=%b key=%b ready=%b busy=%b, required 1 0 1 0",
                 d, c, inv[d], key[d], rdy[d], bsy[d]);
      end
      return;
    end
    seen = 1'b0;
    for (int k = 0; k < exp_q.size(); k++) begin
      if (stop_after >= 0 && k == stop_after) return;
      n_chk++;
      if (key[d] !== exp_q[k] || bsy[d] !== 1'b1 || rdy[d] !== 1'b0 || inv[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL key d%0d char=%h k=%0d: key=%b busy=%b ready=%b inv=%b, required %b 1 0 0",
                 d, c, k, key[d], bsy[d], rdy[d], inv[d], exp_q[k]);
      end
      if (key[d] === 1'b1) begin
        if (!seen) first_mark[d] = cyc;
        seen = 1'b1;
        last_mark[d] = cyc;
      end
      @(negedge clk);
    end
    n_chk++;
    if (rdy[d] !== 1'b1 || bsy[d] !== 1'b0 || key[d] !== 1'b0) begin
      n_fail++;
      $display("FAIL end d%0d char=%h: ready=%b busy=%b key=%b, required 1 0 0",
               d, c, rdy[d], bsy[d], key[d]);
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if (rdy[d] !== 1'b1 || key[d] !== 1'b0 || bsy[d] !== 1'b0 || inv[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset d%0d: ready=%b key=%b busy=%b inv=%b, required 1 0 0 0",
                 d, rdy[d], key[d], bsy[d], inv[d]);
      end
    end
  endtask

  task automatic test_single();
    send(0, "E", -1);
    send(1, "E", -1);
    send(1, "T", -1);
  endtask

  task automatic test_back_to_back();
    int last0;
    send(0, "0", -1);
    last0 = last_mark[0];
    send(0, "a", -1);
    n_chk++;
    if (first_mark[0] - last0 - 1 != 3 * UA + 1) begin
      n_fail++;
      $display("FAIL letter_spacing: low cycles=%0d, required %0d",
               first_mark[0] - last0 - 1, 3 * UA + 1);
    end
  endtask

  task automatic test_word_gap();
    int last_t;
    send(0, "T", -1);
    last_t = last_mark[0];
    send(0, " ", -1);
    send(0, "T", -1);
    // letter gap, idle, word gap, idle
    n_chk++;
    if (first_mark[0] - last_t - 1 != 3 * UA + 1 + 4 * UA + 1) begin
      n_fail++;
      $display("FAIL word_spacing: low cycles=%0d, required %0d",
               first_mark[0] - last_t - 1, 7 * UA + 2);
    end
  endtask

  task automatic test_invalid();
    send(0, "#", -1);
    @(negedge clk);
    n_chk++;
    if (inv[0] !== 1'b0 || key[0] !== 1'b0 || rdy[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL invalid_pulse_width: inv=%b key=%b ready=%b, required 0 0 1",
               inv[0], key[0], rdy[0]);
    end
    send(1, 8'h80, -1);
    send(1, "#", -1);
    send(1, "S", -1);
  endtask

  task automatic test_punct();
    send(1, "?", -1);
    send(1, ".", -1);
    send(0, "/", -1);
  endtask

  task automatic test_reset_mid();
    send(0, "Q", 4 * UA + 1);
    rst[0] = 1'b1;
    @(negedge clk);
    n_chk++;
    if (key[0] !== 1'b0 || rdy[0] !== 1'b1 || bsy[0] !== 1'b0 || inv[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: key=%b ready=%b busy=%b inv=%b, required 0 1 0 0",
               key[0], rdy[0], bsy[0], inv[0]);
    end
    rst[0] = 1'b0;
    send(0, "E", -1);
  endtask

  function automatic logic [7:0] rand_char();
    logic [7:0] pun [5];
    pun[0] = "."; pun[1] = ","; pun[2] = "?"; pun[3] = "/"; pun[4] = "=";
    case ($urandom_range(0, 5))
      0:       return 8'h41 + 8'($urandom_range(0, 25));
      1:       return 8'h61 + 8'($urandom_range(0, 25));
      2:       return 8'h30 + 8'($urandom_range(0, 9));
      3:       return 8'h20;
      4:       return pun[$urandom_range(0, 4)];
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  task automatic test_random();
    for (int i = 0; i < 24; i++) send(1, rand_char(), -1);
    for (int i = 0; i < 8; i++)  send(0, rand_char(), -1);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1;
      vld[d] = 1'b0;
      ain[d] = 8'h00;
      first_mark[d] = 0;
      last_mark[d]  = 0;
    end
    repeat (2) @(negedge clk);
    test_reset();
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(negedge clk);
    test_single();
    test_back_to_back();
    test_word_gap();
    test_invalid();
    test_punct();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
